// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: registered request/acknowledge MMIO bus controller routing CPU accesses to NSLV slave channels.
// Optional macro BUS_TIMEOUT_EN adds an ack timeout that completes the access and sets a sticky bus_err.
module mio_bus_ctrl #(
    parameter int                NSLV       = 4,
    parameter int                DW         = 32,
    parameter logic [NSLV*4-1:0] SLV_REGION = 16'hCFE0,
    parameter int                TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_ready,
    output logic [NSLV-1:0]   slv_sel,
    output logic              slv_we,
    output logic [NSLV-1:0]   slv_rd,
    output logic [31:0]       slv_addr,
    output logic [DW-1:0]     slv_wdata,
    input  logic [NSLV*DW-1:0] slv_rdata,
    input  logic [NSLV-1:0]   slv_ack,
    output logic              bus_err
);

    localparam int CHW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [NSLV-1:0] SEL_ONE = NSLV'(1);

    if (NSLV < 2 || NSLV > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mio_bus_ctrl: NSLV or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state_q, state_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [CHW-1:0]  dec_ch;
    logic [NSLV-1:0] slv_sel_q, slv_sel_d;
    logic [NSLV-1:0] slv_rd_q, slv_rd_d;
    logic            slv_we_q, slv_we_d;
    logic [31:0]     slv_addr_q, slv_addr_d;
    logic [DW-1:0]   slv_wdata_q, slv_wdata_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic            cpu_ready_q, cpu_ready_d;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    // Lowest-numbered matching channel wins, so scan downwards and let later hits override.
    always_comb begin
        dec_ch = '0;
        for (int i = NSLV - 1; i >= 1; i--) begin
            if (SLV_REGION[i*4 +: 4] == cpu_addr[31:28]) begin
                dec_ch = CHW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        slv_sel_d   = slv_sel_q;
        slv_rd_d    = '0;
        slv_we_d    = slv_we_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d     = ACCESS;
                    ch_d        = dec_ch;
                    slv_sel_d   = SEL_ONE << dec_ch;
                    slv_rd_d    = cpu_we ? '0 : (SEL_ONE << dec_ch);
                    slv_we_d    = cpu_we;
                    slv_addr_d  = cpu_addr;
                    slv_wdata_d = cpu_wdata;
`ifdef BUS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ACCESS: begin
                if (slv_ack[ch_q]) begin
                    state_d     = DONE;
                    cpu_ready_d = 1'b1;
                    slv_sel_d   = '0;
                    slv_we_d    = 1'b0;
                    cpu_rdata_d = slv_we_q ? '0 : slv_rdata[int'(ch_q) * DW +: DW];
                end
`ifdef BUS_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d     = DONE;
                        cpu_ready_d = 1'b1;
                        slv_sel_d   = '0;
                        slv_we_d    = 1'b0;
                        cpu_rdata_d = slv_we_q ? '0 : DW'(32'hDEADBEEF);
                        bus_err_d   = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            slv_sel_q   <= '0;
            slv_rd_q    <= '0;
            slv_we_q    <= 1'b0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            slv_sel_q   <= slv_sel_d;
            slv_rd_q    <= slv_rd_d;
            slv_we_q    <= slv_we_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign slv_sel   = slv_sel_q;
    assign slv_rd    = slv_rd_q;
    assign slv_we    = slv_we_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;
`ifdef BUS_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed self-checking bench for mio_bus_ctrl; the BUS_TIMEOUT_EN section runs only when that macro is defined.
module tb_mio_bus_ctrl;

    localparam int NSLV = 4;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_req;
    logic            cpu_we;
    logic [31:0]     cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_ready;
    logic [NSLV-1:0] slv_sel;
    logic            slv_we;
    logic [NSLV-1:0] slv_rd;
    logic [31:0]     slv_addr;
    logic [DW-1:0]   slv_wdata;
    logic [NSLV*DW-1:0] slv_rdata;
    logic [NSLV-1:0] slv_ack;
    logic            bus_err;

    logic [DW-1:0]   d0, d1, d2, d3;
    int              tests = 0;
    int              fails = 0;

    assign slv_rdata = {d3, d2, d1, d0};

    mio_bus_ctrl #(
        .NSLV(NSLV), .DW(DW), .SLV_REGION(16'hCFE0), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .slv_sel(slv_sel), .slv_we(slv_we),
        .slv_rd(slv_rd), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_rdata(slv_rdata), .slv_ack(slv_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [DW-1:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    initial begin
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; slv_ack = '0;
        d0 = 32'h1234_5678; d1 = 32'h1111_1111; d2 = 32'h2222_2222; d3 = 32'h3333_3333;
        step(); step();
        checkOutput("rst_ready", 64'(cpu_ready), 64'd0);
        checkOutput("rst_sel",   64'(slv_sel),   64'd0);
        checkOutput("rst_rd",    64'(slv_rd),    64'd0);
        checkOutput("rst_we",    64'(slv_we),    64'd0);
        checkOutput("rst_rdata", 64'(cpu_rdata), 64'd0);
        checkOutput("rst_err",   64'(bus_err),   64'd0);
        rst = 1'b1;
        step();

        // Read from RAM channel, ack in first ACCESS cycle
        applyStimulus(1'b0, 32'h0000_0010, '0);
        step();
        checkOutput("t1_sel",   64'(slv_sel),   64'h1);
        checkOutput("t1_rd",    64'(slv_rd),    64'h1);
        checkOutput("t1_addr",  64'(slv_addr),  64'h10);
        checkOutput("t1_ready0", 64'(cpu_ready), 64'd0);
        slv_ack = 4'b0001;
        step();
        checkOutput("t1_ready", 64'(cpu_ready), 64'd1);
        checkOutput("t1_rdata", 64'(cpu_rdata), 64'h1234_5678);
        checkOutput("t1_sel_done", 64'(slv_sel), 64'd0);
        checkOutput("t1_rd_done",  64'(slv_rd),  64'd0);
        cpu_req = 1'b0; slv_ack = '0;
        step();
        checkOutput("t1_ready_pulse", 64'(cpu_ready), 64'd0);
        checkOutput("t1_rdata_hold",  64'(cpu_rdata), 64'h1234_5678);

        // Write to channel 1 with three wait cycles
        applyStimulus(1'b1, 32'hE000_0000, 32'h0000_AA55);
        step();
        checkOutput("t2_sel",   64'(slv_sel),   64'h2);
        checkOutput("t2_we",    64'(slv_we),    64'd1);
        checkOutput("t2_wdata", 64'(slv_wdata), 64'hAA55);
        checkOutput("t2_rd",    64'(slv_rd),    64'd0);
        step();
        checkOutput("t2_wait1", 64'(cpu_ready), 64'd0);
        step(); step();
        checkOutput("t2_wait3", 64'(cpu_ready), 64'd0);
        checkOutput("t2_sel_hold", 64'(slv_sel), 64'h2);
        slv_ack = 4'b0010;
        step();
        checkOutput("t2_ready", 64'(cpu_ready), 64'd1);
        cpu_req = 1'b0; slv_ack = '0;
        step();

        // Read channel 2 while channel 3 acks spuriously
        slv_ack = 4'b1000;
        applyStimulus(1'b0, 32'hF000_0008, '0);
        step();
        checkOutput("t3_sel", 64'(slv_sel), 64'h4);
        checkOutput("t3_rd",  64'(slv_rd),  64'h4);
        step();
        checkOutput("t3_noearly1", 64'(cpu_ready), 64'd0);
        step();
        checkOutput("t3_noearly2", 64'(cpu_ready), 64'd0);
        slv_ack = 4'b1100;
        step();
        checkOutput("t3_ready", 64'(cpu_ready), 64'd1);
        checkOutput("t3_rdata", 64'(cpu_rdata), 64'h2222_2222);
        cpu_req = 1'b0; slv_ack = 4'b1000;
        step();
        checkOutput("t3_idle_ack_ignored", 64'(cpu_ready), 64'd0);
        slv_ack = '0;
        step();

        // Unmapped region goes to channel 0; held request is re-accepted three cycles later
        d0 = 32'h5555_AAAA;
        slv_ack = 4'b0001;
        applyStimulus(1'b0, 32'h5000_0000, '0);
        step();
        checkOutput("t4_sel", 64'(slv_sel), 64'h1);
        cpu_addr = 32'hF000_0000;
        step();
        checkOutput("t4_ready",   64'(cpu_ready), 64'd1);
        checkOutput("t4_rdata",   64'(cpu_rdata), 64'h5555_AAAA);
        checkOutput("t4_addr_hold", 64'(slv_addr), 64'h5000_0000);
        step();
        checkOutput("t4_done_noaccept", 64'(slv_sel), 64'd0);
        step();
        checkOutput("t4_b2b_sel",  64'(slv_sel),  64'h4);
        checkOutput("t4_b2b_addr", 64'(slv_addr), 64'hF000_0000);
        slv_ack = 4'b0101;
        step();
        checkOutput("t4_b2b_rdata", 64'(cpu_rdata), 64'h2222_2222);
        cpu_req = 1'b0; slv_ack = '0;
        step();

        // Asynchronous reset in the middle of an access
        applyStimulus(1'b0, 32'hC000_0004, '0);
        step();
        checkOutput("t5_sel", 64'(slv_sel), 64'h8);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_async_sel",   64'(slv_sel),   64'd0);
        checkOutput("t5_async_rd",    64'(slv_rd),    64'd0);
        checkOutput("t5_async_addr",  64'(slv_addr),  64'd0);
        checkOutput("t5_async_rdata", 64'(cpu_rdata), 64'd0);
        cpu_req = 1'b0; slv_ack = 4'b1000;
        #1 rst = 1'b1;
        step();
        checkOutput("t5_no_ready", 64'(cpu_ready), 64'd0);
        slv_ack = '0;
        applyStimulus(1'b0, 32'hE000_0010, '0);
        step();
        checkOutput("t5_new_sel", 64'(slv_sel), 64'h2);
        slv_ack = 4'b0010;
        step();
        checkOutput("t5_new_ready", 64'(cpu_ready), 64'd1);
        checkOutput("t5_new_rdata", 64'(cpu_rdata), 64'h1111_1111);
        cpu_req = 1'b0; slv_ack = '0;
        step();

`ifdef BUS_TIMEOUT_EN
        // Timeout on an unacknowledged read
        applyStimulus(1'b0, 32'hC000_0000, '0);
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("t6_wait", 64'(cpu_ready), 64'd0);
        end
        step();
        checkOutput("t6_ready", 64'(cpu_ready), 64'd1);
        checkOutput("t6_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
        checkOutput("t6_err",   64'(bus_err),   64'd1);
        cpu_req = 1'b0;
        step(); step();
        checkOutput("t6_err_sticky", 64'(bus_err), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("t6_err_reset", 64'(bus_err), 64'd0);
        rst = 1'b1;
        step();
`else
        checkOutput("no_timeout_err", 64'(bus_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Parametrised, registered memory-mapped I/O bus controller between the CPU data port and NSLV peripheral channels.
- Channel 0 is the default data RAM. Channels 1..NSLV-1 are decoded by address region code addr[31:28].
- Replaces the purely combinational decode with a request/acknowledge handshake, so slaves may insert wait states. Read data to the CPU is registered.
- Each accepted read produces a one-cycle read strobe to the selected slave, for FIFO-style devices such as the keyboard.

Parameters:
- NSLV, 4, number of slave channels (2..8); channel 0 is the default RAM.
- DW, 32, data width.
- SLV_REGION, 16'hCFE0, flattened NSLV*4 region codes; channel i uses bits [i*4+:4]; the channel 0 field is ignored.
- TIMEOUT, 255, ack timeout in cycles (used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- cpu_req  in  1  access request; held by the CPU until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  DW  write data
- cpu_rdata  out  DW  registered read data, valid when cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- slv_sel  out  NSLV  one-hot channel select, held for the whole access
- slv_we  out  1  write enable, qualified by slv_sel
- slv_rd  out  NSLV  one-hot one-cycle read strobe, first ACCESS cycle of a read
- slv_addr  out  32  registered copy of cpu_addr
- slv_wdata  out  DW  registered copy of cpu_wdata
- slv_rdata  in  NSLV*DW  flattened slave read data; channel i at [i*DW+:DW]
- slv_ack  in  NSLV  per-channel acknowledge
- bus_err  out  1  sticky timeout flag (BUS_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; all outputs 0; internal counters 0.
- Decode: region=cpu_addr[31:28]. The lowest i in 1..NSLV-1 with SLV_REGION[i*4+:4]==region wins. No match selects channel 0.
- FSM states:
  - IDLE: when cpu_req=1, latch addr, wdata, we and decoded channel; go to ACCESS.
  - ACCESS: slv_sel[ch]=1 and slv_we=latched we. slv_rd[ch]=1 only in the first ACCESS cycle and only for reads. When slv_ack[ch]=1, capture slv_rdata[ch*DW+:DW] into cpu_rdata (reads only; writes capture 0) and go to DONE.
  - DONE: cpu_ready=1 for exactly one cycle; slv_sel=0; go to IDLE.
- Latency: cpu_req sampled at edge 0. ACCESS is entered at edge 1. Ack in the first ACCESS cycle gives cpu_ready=1 in the cycle after edge 2. Minimum is 2 cycles request-to-ready; each wait cycle adds 1.
- Ack rules:
  - slv_ack on unselected channels is ignored.
  - slv_ack in IDLE or DONE is ignored.
- cpu_req: a change while not IDLE is ignored. A request still high in the DONE cycle is not re-accepted; it is accepted in IDLE on the next cycle, so back-to-back accesses are 3 cycles apart.
- cpu_rdata holds its last value until the next read completes.
- Reset asserted mid-access aborts immediately. No cpu_ready is produced and slv_sel returns to 0.
- Address and data are not modified; slaves perform their own word/halfword slicing.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT, go to DONE with cpu_rdata=32'hDEADBEEF (reads) and set bus_err=1.
  - bus_err stays set until reset.
  - An ack arriving in the same cycle as the timeout takes priority.
- Without the macro: no counter; ACCESS waits indefinitely; bus_err is constant 0.

Test Plan:
- Reset, then read 0x0000_0010; channel 0 acks in the first cycle with 0x1234_5678 -> slv_sel=4'b0001, slv_rd=4'b0001 for 1 cycle, cpu_ready 2 cycles after the request, cpu_rdata=0x1234_5678.
- Write 0xE000_0000 data 0xAA55 -> slv_sel=4'b0010, slv_we=1, slv_wdata=0xAA55, slv_rd=0; ack after 3 wait cycles gives cpu_ready 5 cycles after the request.
- Read 0xF000_0008 with slv_ack[3] forced high and slv_ack[2] delayed 2 cycles -> no early completion; cpu_rdata=channel 2 data.
- Read 0x5000_0000 (unmapped region) -> routed to channel 0; back-to-back second request accepted 3 cycles after the first.
- Drive rst=0 during ACCESS to 0xC000_0004 -> all outputs 0 asynchronously, no cpu_ready; after release a new read completes normally.
- BUS_TIMEOUT_EN, TIMEOUT=8, read 0xC000_0000 with no ack -> cpu_ready after the 8-cycle timeout, cpu_rdata=0xDEADBEEF, bus_err=1 until reset.
